gmii_tx_mac: RTL and testbench

Ethernet transmit framer on the GMII transmit side of the RGMII bridge. It accepts a payload byte stream with a valid/ready/last handshake and drives `gmii_tx_en` and `gmii_txd`. It adds the preamble and SFD, optionally pads short frames, appends the CRC-32 FCS, and enforces the inter-frame gap. Its outputs connect directly to the bridge's `gmii_tx_en` and `gmii_txd` inputs, and it runs on `gmii_tx_clk`.

---
 rtl/gmii_tx_mac_pkg.sv | 24 ++
 rtl/crc32_d8.sv | 20 ++
 rtl/gmii_tx_mac.sv | 189 ++++++++++++++++++
 tb/tb_gmii_tx_mac.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_mac_pkg.sv
// gmii_tx_mac_pkg: state encoding and framing/CRC constants shared by the GMII
// transmit framer and the matching receive FCS checker.
package gmii_tx_mac_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPre  = 3'd1,
      StSfd  = 3'd2,
      StData = 3'd3,
      StPad  = 3'd4,
      StFcs  = 3'd5,
      StGap  = 3'd6
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int unsigned PREAMBLE_LEN  = 7;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   // Register value left after running the CRC over data plus a correct FCS.
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update over one byte (LSB first).
module crc32_d8
   import gmii_tx_mac_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   // Eight serial LFSR steps unrolled into a single combinational stage.
   always_comb begin
      logic [31:0] c;
      c = crc_i ^ {24'h000000, data_i};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      crc_o = c;
   end

endmodule

// File: rtl/gmii_tx_mac.sv
// gmii_tx_mac: GMII transmit framer. Adds preamble/SFD, appends the CRC-32 FCS
// and enforces the inter-frame gap. Build option GMII_TX_PAD_EN zero-pads
// frames shorter than MIN_FRAME bytes (padding is covered by the FCS).
module gmii_tx_mac
   import gmii_tx_mac_pkg::*;
#(
   parameter int unsigned IFG_CYCLES = 12,
   parameter int unsigned MIN_FRAME  = 60
) (
   input  logic       gmii_tx_clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_underrun
);

   if (IFG_CYCLES < 1 || IFG_CYCLES > 255 || MIN_FRAME > 2047) begin : g_bad_param
      $error("gmii_tx_mac: IFG_CYCLES or MIN_FRAME out of range");
   end

   tx_state_e   state_q, state_d;
   logic [2:0]  sub_cnt_q, sub_cnt_d;   // preamble beat, then FCS byte index
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [31:0] crc_q, crc_d, crc_next, fcs;
   logic [7:0]  crc_byte;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  txd_q, txd_d;
   logic        done_q, done_d;
   logic        underrun_q, underrun_d;
`ifdef GMII_TX_PAD_EN
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [11:0] byte_cnt_inc;

   assign byte_cnt_inc = {1'b0, byte_cnt_q} + 12'd1;
`endif

   // Pad bytes are zeros; only DATA folds the live input byte.
   assign crc_byte = (state_q == StData) ? s_data : 8'h00;
   assign fcs      = ~crc_q;

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (crc_byte),
      .crc_o  (crc_next)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_d    = state_q;
      sub_cnt_d  = sub_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      crc_d      = crc_q;
      tx_en_d    = 1'b0;
      txd_d      = 8'h00;
      done_d     = 1'b0;
      underrun_d = 1'b0;
`ifdef GMII_TX_PAD_EN
      byte_cnt_d = byte_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            // First byte stays upstream; it is consumed once DATA is reached.
            if (s_valid) begin
               state_d   = StPre;
               sub_cnt_d = 3'd0;
            end
         end
         StPre: begin
            tx_en_d = 1'b1;
            txd_d   = PREAMBLE_BYTE;
            if (sub_cnt_q == 3'(PREAMBLE_LEN - 1)) begin
               state_d   = StSfd;
               sub_cnt_d = 3'd0;
            end else begin
               sub_cnt_d = sub_cnt_q + 3'd1;
            end
         end
         StSfd: begin
            tx_en_d   = 1'b1;
            txd_d     = SFD_BYTE;
            crc_d     = CRC32_INIT;
            sub_cnt_d = 3'd0;
            state_d   = StData;
`ifdef GMII_TX_PAD_EN
            byte_cnt_d = 11'd0;
`endif
         end
         StData: begin
            if (s_valid) begin
               tx_en_d = 1'b1;
               txd_d   = s_data;
               crc_d   = crc_next;
`ifdef GMII_TX_PAD_EN
               byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_inc[10:0];
               if (s_last) begin
                  state_d = (byte_cnt_inc < 12'(MIN_FRAME)) ? StPad : StFcs;
               end
`else
               if (s_last) begin
                  state_d = StFcs;
               end
`endif
            end else begin
               // Underrun: cut the frame without an FCS so receivers drop it.
               underrun_d = 1'b1;
               gap_cnt_d  = 8'd0;
               state_d    = StGap;
            end
         end
         StPad: begin
`ifdef GMII_TX_PAD_EN
            tx_en_d    = 1'b1;
            txd_d      = 8'h00;
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_inc[10:0];
            if (byte_cnt_inc >= 12'(MIN_FRAME)) begin
               state_d = StFcs;
            end
`else
            state_d = StIdle;
`endif
         end
         StFcs: begin
            tx_en_d = 1'b1;
            txd_d   = fcs[{sub_cnt_q[1:0], 3'b000} +: 8];
            if (sub_cnt_q == 3'd3) begin
               done_d    = 1'b1;
               sub_cnt_d = 3'd0;
               gap_cnt_d = 8'd0;
               state_d   = StGap;
            end else begin
               sub_cnt_d = sub_cnt_q + 3'd1;
            end
         end
         StGap: begin
            if (gap_cnt_q == 8'(IFG_CYCLES - 1)) begin
               gap_cnt_d = 8'd0;
               state_d   = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge gmii_tx_clk) begin
      if (rst) begin
         state_q    <= StIdle;
         sub_cnt_q  <= 3'd0;
         gap_cnt_q  <= 8'd0;
         crc_q      <= CRC32_INIT;
         tx_en_q    <= 1'b0;
         txd_q      <= 8'h00;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
`ifdef GMII_TX_PAD_EN
         byte_cnt_q <= 11'd0;
`endif
      end else begin
         state_q    <= state_d;
         sub_cnt_q  <= sub_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         crc_q      <= crc_d;
         tx_en_q    <= tx_en_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
`ifdef GMII_TX_PAD_EN
         byte_cnt_q <= byte_cnt_d;
`endif
      end
   end

   assign s_ready     = (state_q == StData);
   assign tx_busy     = (state_q != StIdle);
   assign gmii_tx_en  = tx_en_q;
   assign gmii_txd    = txd_q;
   assign tx_done     = done_q;
   assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_gmii_tx_mac.sv
// tb_gmii_tx_mac: self-checking bench for gmii_tx_mac. A per-cycle trace of the
// outputs is compared against a frame-level model (preamble, payload, optional
// padding, CRC-32 FCS computed from its definition).
module tb_gmii_tx_mac;
   import gmii_tx_mac_pkg::*;

   localparam int unsigned IFG  = 12;
   localparam int unsigned MINF = 60;

   localparam int F_DONE = 0;
   localparam int F_UND  = 1;
   localparam int F_RDY  = 2;
   localparam int F_IDLE = 3;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic       en;
      logic [7:0] d;
      logic       done;
      logic       und;
      logic       busy;
      logic       rdy;
   } samp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_last = 1'b0;
   logic       s_ready, gmii_tx_en, tx_busy, tx_done, tx_underrun;
   logic [7:0] gmii_txd;

   int tests = 0;
   int fails = 0;
   samp_t trace[$];

   gmii_tx_mac #(
      .IFG_CYCLES (IFG),
      .MIN_FRAME  (MINF)
   ) dut (
      .gmii_tx_clk (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_underrun (tx_underrun)
   );

   always #4 clk = ~clk;

   // One sample per cycle, taken mid-cycle.
   always @(negedge clk) begin : capture
      samp_t s;
      s.en   = gmii_tx_en;
      s.d    = gmii_txd;
      s.done = tx_done;
      s.und  = tx_underrun;
      s.busy = tx_busy;
      s.rdy  = s_ready;
      trace.push_back(s);
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] crc_reg(input byte_q_t b);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic byte_q_t wire_model(input byte_q_t pl);
      byte_q_t     body;
      byte_q_t     w;
      logic [31:0] fcs;
      body = pl;
`ifdef GMII_TX_PAD_EN
      while (body.size() < MINF) body.push_back(8'h00);
`endif
      fcs = ~crc_reg(body);
      for (int k = 0; k < 7; k++) w.push_back(8'h55);
      w.push_back(8'hD5);
      foreach (body[i]) w.push_back(body[i]);
      for (int k = 0; k < 4; k++) w.push_back(fcs[8*k +: 8]);
      return w;
   endfunction

   function automatic byte_q_t rand_payload(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      return q;
   endfunction

   // ---------------- trace analysis ----------------
   task automatic get_run(input int from, output int start, output int len);
      start = -1;
      len   = 0;
      for (int i = from; i < trace.size(); i++) begin
         if (trace[i].en === 1'b1) begin
            if (start < 0) start = i;
            len++;
         end else if (start >= 0) begin
            break;
         end
      end
   endtask

   function automatic int diff_wire(input int st, input byte_q_t exp);
      for (int k = 0; k < exp.size(); k++) begin
         if (st < 0 || st + k >= trace.size()) return k;
         if (trace[st+k].en !== 1'b1 || trace[st+k].d !== exp[k]) return k;
      end
      return -1;
   endfunction

   function automatic int count_flag(input int which, input int from, input int to);
      int n;
      n = 0;
      for (int i = (from < 0 ? 0 : from); i < to && i < trace.size(); i++) begin
         case (which)
            F_DONE:  if (trace[i].done === 1'b1) n++;
            F_UND:   if (trace[i].und === 1'b1) n++;
            F_RDY:   if (trace[i].rdy === 1'b1) n++;
            default: if (trace[i].busy === 1'b0) n++;
         endcase
      end
      return n;
   endfunction

   function automatic int first_flag(input int which, input int from);
      for (int i = (from < 0 ? 0 : from); i < trace.size(); i++) begin
         if (which == F_DONE && trace[i].done === 1'b1) return i;
         if (which == F_UND && trace[i].und === 1'b1) return i;
      end
      return -1;
   endfunction

   // ---------------- drivers (called at posedge + 1) ----------------
   task automatic drive_frame(input byte_q_t pl, input int stop_after);
      int   i;
      int   budget;
      logic rdy;
      i      = 0;
      budget = 0;
      while (i < stop_after) begin
         s_valid = 1'b1;
         s_data  = pl[i];
         s_last  = (i == int'(pl.size()) - 1);
         rdy     = s_ready;
         @(posedge clk); #1;
         if (rdy === 1'b1) begin
            i++;
         end else begin
            budget++;
            if (budget > 4000) begin
               tests++;
               fails++;
               $display("FAIL drive_timeout: accepted %0d of %0d bytes", i, stop_after);
               break;
            end
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      // Hold s_valid low for one DATA cycle to provoke an underrun.
      if (stop_after < int'(pl.size())) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (tx_busy !== 1'b0) begin
         @(posedge clk); #1;
         n++;
         if (n > 1000) begin
            tests++;
            fails++;
            $display("FAIL %s_idle_timeout: tx_busy=%b after %0d cycles, 0 required", tag, tx_busy, n);
            break;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hAA;
      s_last  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (gmii_tx_en !== 1'b0) begin
         fails++;
         $display("FAIL reset_tx_en: got %b, 0 required", gmii_tx_en);
      end
      tests++;
      if (gmii_txd !== 8'h00) begin
         fails++;
         $display("FAIL reset_txd: got %h, 00 required", gmii_txd);
      end
      tests++;
      if ({s_ready, tx_busy, tx_done, tx_underrun} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: ready/busy/done/und got %b, 0000 required",
                  {s_ready, tx_busy, tx_done, tx_underrun});
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      rst     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({tx_busy, gmii_tx_en} !== 2'b00) begin
         fails++;
         $display("FAIL reset_stays_idle: busy/en got %b, 00 required", {tx_busy, gmii_tx_en});
      end
   endtask

   task automatic test_known_vector();
      byte_q_t pl, exp;
      int st, ln, bad, dn;
      pl  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      exp = wire_model(pl);
      trace.delete();
      drive_frame(pl, pl.size());
      wait_idle("kv");
      get_run(0, st, ln);
      // Edge 1 sees s_valid in IDLE, so the first 0x55 is in the cycle after edge 2.
      tests++;
      if (st != 2) begin
         fails++;
         $display("FAIL kv_latency: first preamble at trace %0d, 2 required", st);
      end
      tests++;
      if (ln != exp.size()) begin
         fails++;
         $display("FAIL kv_en_length: tx_en high %0d cycles, %0d required", ln, exp.size());
      end
      bad = diff_wire(st, exp);
      tests++;
      if (bad != -1) begin
         fails++;
         $display("FAIL kv_wire: first wrong byte index %0d, -1 required", bad);
      end
`ifndef GMII_TX_PAD_EN
      tests++;
      if ({trace[st+17].d, trace[st+18].d, trace[st+19].d, trace[st+20].d} !== 32'h2639F4CB) begin
         fails++;
         $display("FAIL kv_fcs: got %h %h %h %h, 26 39 f4 cb required", trace[st+17].d,
                  trace[st+18].d, trace[st+19].d, trace[st+20].d);
      end
`endif
      dn = first_flag(F_DONE, 0);
      tests++;
      if (count_flag(F_DONE, 0, trace.size()) != 1 || dn != st + ln - 1) begin
         fails++;
         $display("FAIL kv_done: pulse at %0d (count %0d), single pulse at %0d required", dn,
                  count_flag(F_DONE, 0, trace.size()), st + ln - 1);
      end
      tests++;
      if (count_flag(F_RDY, 0, trace.size()) != pl.size()) begin
         fails++;
         $display("FAIL kv_ready: s_ready high %0d cycles, %0d required",
                  count_flag(F_RDY, 0, trace.size()), pl.size());
      end
   endtask

   task automatic test_padding();
      byte_q_t pl, exp, rx;
      int st, ln, bad;
      pl  = rand_payload(14);
      exp = wire_model(pl);
      trace.delete();
      drive_frame(pl, pl.size());
      wait_idle("pad");
      get_run(0, st, ln);
`ifdef GMII_TX_PAD_EN
      tests++;
      if (ln != 8 + 60 + 4) begin
         fails++;
         $display("FAIL pad_length: tx_en high %0d cycles, 72 required", ln);
      end
      bad = -1;
      for (int k = 0; k < 46; k++) begin
         if (trace[st+8+14+k].d !== 8'h00 && bad < 0) bad = k;
      end
      tests++;
      if (bad != -1) begin
         fails++;
         $display("FAIL pad_zeros: first nonzero pad byte %0d, -1 required", bad);
      end
`else
      tests++;
      if (ln != 8 + 14 + 4) begin
         fails++;
         $display("FAIL nopad_length: tx_en high %0d cycles, 26 required", ln);
      end
`endif
      bad = diff_wire(st, exp);
      tests++;
      if (bad != -1) begin
         fails++;
         $display("FAIL pad_wire: first wrong byte index %0d, -1 required", bad);
      end
      for (int k = st + 8; k < st + ln; k++) rx.push_back(trace[k].d);
      tests++;
      if (crc_reg(rx) !== CRC32_RESIDUE) begin
         fails++;
         $display("FAIL pad_residue: got %h, %h required", crc_reg(rx), CRC32_RESIDUE);
      end
   endtask

   task automatic test_random_frames();
      byte_q_t pl, exp;
      int st, ln, bad;
      for (int f = 0; f < 4; f++) begin
         pl  = rand_payload($urandom_range(1, 80));
         exp = wire_model(pl);
         trace.delete();
         drive_frame(pl, pl.size());
         wait_idle("rand");
         get_run(0, st, ln);
         bad = diff_wire(st, exp);
         tests++;
         if (bad != -1 || ln != exp.size()) begin
            fails++;
            $display("FAIL rand_wire[%0d]: len %0d first bad %0d, len %0d bad -1 required", f, ln,
                     bad, exp.size());
         end
         tests++;
         if (first_flag(F_DONE, 0) != st + ln - 1 || count_flag(F_UND, 0, trace.size()) != 0) begin
            fails++;
            $display("FAIL rand_flags[%0d]: done at %0d und %0d, done at %0d und 0 required", f,
                     first_flag(F_DONE, 0), count_flag(F_UND, 0, trace.size()), st + ln - 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      byte_q_t p1, p2, e1, e2;
      int s1, l1, s2, l2;
      p1 = rand_payload($urandom_range(1, 20));
      p2 = rand_payload($urandom_range(1, 20));
      e1 = wire_model(p1);
      e2 = wire_model(p2);
      trace.delete();
      drive_frame(p1, p1.size());
      drive_frame(p2, p2.size());
      wait_idle("b2b");
      get_run(0, s1, l1);
      get_run(s1 + l1, s2, l2);
      tests++;
      if (diff_wire(s1, e1) != -1 || diff_wire(s2, e2) != -1) begin
         fails++;
         $display("FAIL b2b_wire: bad index f1 %0d f2 %0d, -1 required", diff_wire(s1, e1),
                  diff_wire(s2, e2));
      end
      // IFG cycles of GAP plus the IDLE cycle that samples the held s_valid.
      tests++;
      if (s2 - (s1 + l1) != IFG + 1) begin
         fails++;
         $display("FAIL b2b_gap: %0d idle wire cycles, %0d required", s2 - (s1 + l1), IFG + 1);
      end
      tests++;
      if (count_flag(F_IDLE, s1 + l1, s2) != 1) begin
         fails++;
         $display("FAIL b2b_idle_state: %0d non-busy cycles in gap, 1 required",
                  count_flag(F_IDLE, s1 + l1, s2));
      end
      tests++;
      if (count_flag(F_DONE, 0, trace.size()) != 2) begin
         fails++;
         $display("FAIL b2b_done: %0d pulses, 2 required", count_flag(F_DONE, 0, trace.size()));
      end
   endtask

   task automatic test_underrun();
      byte_q_t p1, p2, e1, e2;
      int s1, l1, s2, l2;
      p1 = rand_payload(10);
      p2 = rand_payload($urandom_range(1, 30));
      for (int k = 0; k < 7; k++) e1.push_back(8'h55);
      e1.push_back(8'hD5);
      for (int k = 0; k < 5; k++) e1.push_back(p1[k]);
      e2 = wire_model(p2);
      trace.delete();
      drive_frame(p1, 5);
      drive_frame(p2, p2.size());
      wait_idle("und");
      get_run(0, s1, l1);
      get_run(s1 + l1, s2, l2);
      tests++;
      if (l1 != 13 || diff_wire(s1, e1) != -1) begin
         fails++;
         $display("FAIL und_truncated: len %0d bad %0d, len 13 bad -1 required", l1,
                  diff_wire(s1, e1));
      end
      tests++;
      if (count_flag(F_UND, 0, trace.size()) != 1 || first_flag(F_UND, 0) != s1 + l1) begin
         fails++;
         $display("FAIL und_pulse: count %0d at %0d, 1 at %0d required",
                  count_flag(F_UND, 0, trace.size()), first_flag(F_UND, 0), s1 + l1);
      end
      tests++;
      if (count_flag(F_DONE, 0, s2) != 0) begin
         fails++;
         $display("FAIL und_no_done: %0d pulses before frame 2, 0 required",
                  count_flag(F_DONE, 0, s2));
      end
      // The aborting cycle, IFG cycles of GAP and the IDLE cycle that samples s_valid.
      tests++;
      if (s2 - (s1 + l1) != IFG + 2) begin
         fails++;
         $display("FAIL und_gap: %0d idle wire cycles, %0d required", s2 - (s1 + l1), IFG + 2);
      end
      tests++;
      if (diff_wire(s2, e2) != -1 || l2 != e2.size()) begin
         fails++;
         $display("FAIL und_next_frame: len %0d bad %0d, len %0d bad -1 required", l2,
                  diff_wire(s2, e2), e2.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      byte_q_t p1, e1, p2, e2;
      int st, ln;
      p1 = rand_payload(64);
      e1 = wire_model(p1);
      trace.delete();
      drive_frame(p1, p1.size());
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (gmii_tx_en !== 1'b1 || gmii_txd !== e1[e1.size()-2]) begin
         fails++;
         $display("FAIL rstmid_fcs3: en %b txd %h, en 1 txd %h required", gmii_tx_en, gmii_txd,
                  e1[e1.size()-2]);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({gmii_tx_en, gmii_txd, s_ready, tx_busy, tx_done, tx_underrun} !== 13'h0) begin
         fails++;
         $display("FAIL rstmid_outputs: en %b txd %h rdy %b busy %b done %b und %b, all 0 required",
                  gmii_tx_en, gmii_txd, s_ready, tx_busy, tx_done, tx_underrun);
      end
      rst = 1'b0;
      p2  = rand_payload($urandom_range(1, 40));
      e2  = wire_model(p2);
      trace.delete();
      drive_frame(p2, p2.size());
      wait_idle("rstmid");
      get_run(0, st, ln);
      tests++;
      if (st != 2 || ln != e2.size() || diff_wire(st, e2) != -1) begin
         fails++;
         $display("FAIL rstmid_next_frame: start %0d len %0d bad %0d, start 2 len %0d bad -1 required",
                  st, ln, diff_wire(st, e2), e2.size());
      end
   endtask

   task automatic test_single_byte();
      byte_q_t pl, exp;
      int st, ln;
      pl  = rand_payload(1);
      exp = wire_model(pl);
      trace.delete();
      drive_frame(pl, 1);
      wait_idle("one");
      get_run(0, st, ln);
`ifndef GMII_TX_PAD_EN
      tests++;
      if (ln != 13) begin
         fails++;
         $display("FAIL one_length: tx_en high %0d cycles, 13 required", ln);
      end
`endif
      tests++;
      if (diff_wire(st, exp) != -1) begin
         fails++;
         $display("FAIL one_wire: first bad byte %0d, -1 required", diff_wire(st, exp));
      end
      tests++;
      if (count_flag(F_RDY, 0, trace.size()) != 1) begin
         fails++;
         $display("FAIL one_ready: s_ready high %0d cycles, 1 required",
                  count_flag(F_RDY, 0, trace.size()));
      end
      tests++;
      if (first_flag(F_DONE, 0) != st + ln - 1) begin
         fails++;
         $display("FAIL one_done: pulse at %0d, %0d required", first_flag(F_DONE, 0), st + ln - 1);
      end
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_padding();
      test_random_frames();
      test_back_to_back();
      test_underrun();
      test_reset_mid_frame();
      test_single_byte();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
